// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU instruction-cycle sequencer: default width,
// advance-mode encoding and a one-hot to binary helper.
package cpu_seq_pkg;

  localparam int NCYC_DEFAULT = 8;
  localparam int NCYC_MAX     = 32;

  // How the timing state moves on an edge, in priority order.
  typedef enum logic [2:0] {
    ADV_HOLD  = 3'd0,
    ADV_FETCH = 3'd1,
    ADV_IDLE  = 3'd2,
    ADV_TWO   = 3'd3,
    ADV_ONE   = 3'd4
  } adv_e;

  // Input is assumed one-hot or zero; zero maps to index 0.
  function automatic logic [4:0] onehot_to_bin(input logic [NCYC_MAX-1:0] oh);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < NCYC_MAX; i++) begin
      if (oh[i]) b = b | 5'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder for the sequencer timing state; zero input gives 0.
module onehot_enc
  import cpu_seq_pkg::*;
#(
  parameter  int NCYC = NCYC_DEFAULT,
  localparam int IW   = $clog2(NCYC)
) (
  input  logic [NCYC-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic [NCYC_MAX-1:0] oh_ext;
  logic [4:0]          bin;

  always_comb begin
    oh_ext = '0;
    oh_ext[NCYC-1:0] = onehot;
    bin = onehot_to_bin(oh_ext);
    idx = bin[IW-1:0];
  end

endmodule

// File: rtl/cycle_seq.sv
// One-hot instruction-cycle sequencer: restarts on opcode fetch, freezes on bus
// stall, optionally skips a state and flags sequences that run off the end.
module cycle_seq
  import cpu_seq_pkg::*;
#(
  parameter  int NCYC = NCYC_DEFAULT,
  localparam int IW   = $clog2(NCYC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            next_sync,
  input  logic            rdy,
  input  logic            skip,
  input  logic            err_clr,
  output logic [NCYC-1:0] cycle,
  output logic [IW-1:0]   cycle_idx,
  output logic            active,
  output logic            sync,
  output logic            err
);

  adv_e            adv;
  logic [NCYC-1:0] cycle_nxt;
  logic [IW-1:0]   idx_nxt;
  logic            ovf;

  always_comb begin
    adv = ADV_ONE;
    if (!rdy)                adv = ADV_HOLD;
    else if (next_sync)      adv = ADV_FETCH;
    else if (cycle == '0)    adv = ADV_IDLE;
    else if (skip)           adv = ADV_TWO;
  end

  // Bits shifted past the top are dropped, so an overflowing shift leaves zero.
  always_comb begin
    cycle_nxt = cycle;
    ovf       = 1'b0;
    case (adv)
      ADV_FETCH, ADV_IDLE: cycle_nxt = NCYC'(1);
      ADV_TWO: begin
        cycle_nxt = cycle << 2;
        ovf       = |cycle[NCYC-1:NCYC-2];
      end
      ADV_ONE: begin
        cycle_nxt = cycle << 1;
        ovf       = cycle[NCYC-1];
      end
      default: cycle_nxt = cycle;
    endcase
  end

  onehot_enc #(.NCYC(NCYC)) u_enc (
    .onehot (cycle_nxt),
    .idx    (idx_nxt)
  );

  // State register bank; index and active are registered with cycle so all
  // outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle     <= '0;
      cycle_idx <= '0;
      active    <= 1'b0;
      sync      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (rdy) begin
        cycle     <= cycle_nxt;
        cycle_idx <= idx_nxt;
        active    <= |cycle_nxt;
        sync      <= next_sync;
      end
      // Set wins over clear on the same edge.
      if (ovf)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cycle_seq.sv
// Directed self-checking bench for cycle_seq with NCYC=8.
module tb_cycle_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       next_sync, rdy, skip, err_clr;
  logic [7:0] cycle;
  logic [2:0] cycle_idx;
  logic       active, sync, err;

  int tests = 0;
  int fails = 0;

  cycle_seq #(.NCYC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_sync (next_sync),
    .rdy       (rdy),
    .skip      (skip),
    .err_clr   (err_clr),
    .cycle     (cycle),
    .cycle_idx (cycle_idx),
    .active    (active),
    .sync      (sync),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Observed vector: {cycle, cycle_idx, active, sync, err}
  logic [13:0] obs;
  assign obs = {cycle, cycle_idx, active, sync, err};

  function automatic logic [13:0] exp_vec(input logic [7:0] c, input logic [2:0] i,
                                          input logic s, input logic e);
    return {c, i, (c != 8'h00), s, e};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [13:0] exp;
    rst_n = 1'b0; next_sync = 0; rdy = 1; skip = 0; err_clr = 0;
    #12;
    tests++;
    if (obs !== 14'h0) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", obs, 14'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      exp = exp_vec(8'(1 << i), 3'(i), 1'b0, 1'b0);
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL walk_T%0d got=%h exp=%h", i, obs, exp);
      end
    end
    tick;
    exp = exp_vec(8'h00, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL walk_overflow got=%h exp=%h", obs, exp);
    end
    tick;
    exp = exp_vec(8'h01, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL walk_restart got=%h exp=%h", obs, exp);
    end
    err_clr = 1;
    tick;
    err_clr = 0;
    exp = exp_vec(8'h02, 3'd1, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL walk_err_clr got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_next_sync;
    logic [13:0] exp;
    for (int i = 2; i <= 4; i++) begin
      tick;
      exp = exp_vec(8'(1 << i), 3'(i), 1'b0, 1'b0);
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL ns_walk_T%0d got=%h exp=%h", i, obs, exp);
      end
    end
    next_sync = 1;
    tick;
    exp = exp_vec(8'h01, 3'd0, 1'b1, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL ns_restart got=%h exp=%h", obs, exp);
    end
    skip = 1;
    tick;
    exp = exp_vec(8'h01, 3'd0, 1'b1, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL ns_with_skip got=%h exp=%h", obs, exp);
    end
    next_sync = 0; skip = 0;
    tick;
    exp = exp_vec(8'h02, 3'd1, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL ns_release got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_skip;
    logic [13:0] exp;
    skip = 1;
    tick;
    exp = exp_vec(8'h08, 3'd3, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_02 got=%h exp=%h", obs, exp);
    end
    skip = 0;
    tick; tick; tick;
    exp = exp_vec(8'h40, 3'd6, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_reach_40 got=%h exp=%h", obs, exp);
    end
    skip = 1;
    tick;
    exp = exp_vec(8'h00, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_40_ovf got=%h exp=%h", obs, exp);
    end
    skip = 0;
    tick;
    exp = exp_vec(8'h01, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_idle_restart got=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 7; i++) tick;
    exp = exp_vec(8'h80, 3'd7, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_reach_80 got=%h exp=%h", obs, exp);
    end
    skip = 1;
    tick;
    skip = 0;
    exp = exp_vec(8'h00, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL skip_80_ovf got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_err_clr;
    logic [13:0] exp;
    tick;
    err_clr = 1;
    tick;
    err_clr = 0;
    exp = exp_vec(8'h02, 3'd1, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL clr_normal got=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 6; i++) tick;
    exp = exp_vec(8'h80, 3'd7, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL clr_reach_80 got=%h exp=%h", obs, exp);
    end
    err_clr = 1;
    tick;
    exp = exp_vec(8'h00, 3'd0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL clr_on_ovf got=%h exp=%h", obs, exp);
    end
    tick;
    err_clr = 0;
    exp = exp_vec(8'h01, 3'd0, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL clr_after_ovf got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_stall;
    logic [13:0] exp;
    tick; tick;
    rdy = 0; next_sync = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      exp = exp_vec(8'h04, 3'd2, 1'b0, 1'b0);
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, exp);
      end
    end
    rdy = 1; next_sync = 0;
    tick;
    exp = exp_vec(8'h08, 3'd3, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL stall_resume got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_async_reset;
    logic [13:0] exp;
    tick; tick;
    exp = exp_vec(8'h20, 3'd5, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL areset_pre got=%h exp=%h", obs, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 14'h0) begin
      fails++; $display("FAIL areset_mid_cycle got=%h exp=%h", obs, 14'h0);
    end
    #3 rst_n = 1'b1;
    tick;
    exp = exp_vec(8'h01, 3'd0, 1'b0, 1'b0);
    tests++;
    if (obs !== exp) begin
      fails++; $display("FAIL areset_release got=%h exp=%h", obs, exp);
    end
  endtask

  initial begin
    test_reset;
    test_next_sync;
    test_skip;
    test_err_clr;
    test_stall;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
